uart_cmd_frame_tx: RTL and testbench
====================================

UART_CMD_FRAME_TX -- requirements
Module: uart_cmd_frame_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART payload byte width.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6, width of the bit-period control.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: CLK input 1, rising-edge clock; RST input 1, asynchronous active-high reset.
REQ-004 SHALL have CMD_VALID input 1, command request.
REQ-005 SHALL have CMD_READY output 1, high when idle and able to accept.
REQ-006 SHALL have CMD_TYPE input 2: 00 RF write, 01 RF read, 10 ALU with operands, 11 ALU without operands.
REQ-007 SHALL have CMD_ADDR input DATA_WIDTH, register-file address.
REQ-008 SHALL have CMD_DATA_A input DATA_WIDTH, write data or ALU operand A.
REQ-009 SHALL have CMD_DATA_B input DATA_WIDTH, ALU operand B.
REQ-010 SHALL have CMD_FUN input DATA_WIDTH, ALU function code.
REQ-011 SHALL have PAR_EN input 1 (parity enable) and PAR_TYP input 1 (0 even, 1 odd).
REQ-012 SHALL have PRESCALE input PRESCALE_WIDTH, CLK cycles per bit.
REQ-013 SHALL have TX_OUT output 1, serial line, idle high.
REQ-014 SHALL have BUSY output 1, high while a command is in flight.
REQ-015 SHALL have CMD_DONE output 1, one-cycle pulse after the last byte completes.

Function
REQ-016 SHALL accept a command on the rising CLK edge where CMD_VALID and CMD_READY are both high, capturing all CMD_* fields, PAR_EN, PAR_TYP and PRESCALE; later input changes SHALL NOT affect the command in flight.
REQ-017 SHALL drop CMD_READY and raise BUSY in the cycle after accept.
REQ-018 SHALL send these byte sequences: RF write AA, ADDR, DATA_A; RF read BB, ADDR; ALU with operands CC, DATA_A, DATA_B, FUN; ALU without operands DD, FUN.
REQ-019 SHALL frame every byte as: start bit 0, 8 data bits LSB first, parity bit only if PAR_EN, stop bit 1, then one idle gap bit 1.
REQ-020 SHALL set the parity bit to XOR-reduce(byte) for even parity and to its inverse for odd parity.
REQ-021 SHALL hold each bit on TX_OUT for exactly P CLK cycles, where P = max(PRESCALE, 4), and SHALL begin the start bit in the first cycle after accept.
REQ-022 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP and GAP:
- IDLE to START on accept.
- START to DATA.
- DATA to PARITY after the 8th bit if PAR_EN, else to STOP.
- PARITY to STOP, then STOP to GAP.
- GAP to START if bytes remain, else to IDLE.
REQ-023 SHALL use a 3-bit bit index and a 2-bit byte index, both cleared on every transition out of IDLE.
REQ-024 SHALL produce a command duration of exactly N x (11 + PAR_EN) x P cycles, where N is the byte count (2, 3 or 4).
REQ-025 SHALL pulse CMD_DONE in the final GAP cycle, and SHALL raise CMD_READY and drop BUSY in the following cycle.
REQ-026 SHALL ignore CMD_VALID while BUSY, with no queuing and no effect on the command in flight.
REQ-027 SHALL accept back-to-back commands: CMD_VALID held high is accepted in the first cycle CMD_READY is high, giving no extra idle beyond the GAP bit.
REQ-028 SHALL keep TX_OUT glitch-free; it SHALL be driven from a flop, never combinationally.

Reset
REQ-029 SHALL, while RST is high, immediately force: TX_OUT=1, CMD_READY=1, BUSY=0, CMD_DONE=0, FSM=IDLE, all counters 0, captured fields 0.
REQ-030 SHALL, when RST asserts mid-command, abort the command with no CMD_DONE, and SHALL allow the first accept on the first rising edge after RST deasserts.

Structure
REQ-031 SHALL take from shared package uart_cmd_pkg: opcode constants RF_WR_CMD=AA, RF_RD_CMD=BB, ALU_W_OP_CMD=CC, ALU_W_NOP_CMD=DD; the CMD_TYPE encodings; and the FSM state encoding.
REQ-032 SHALL contain one sub-module, uart_baud_tick, that counts 0..P-1, emits a one-cycle bit_tick at P-1, and restarts on a load strobe issued at accept.

Verification
REQ-033 SHALL verify: RF write, ADDR=14, DATA_A=69, PAR_EN=1, PAR_TYP=0, PRESCALE=8 -> TX_OUT decodes AA(p0), 14(p0), 69(p0); CMD_DONE exactly 288 cycles after accept.
REQ-034 SHALL verify: RF read, ADDR=18, PAR_EN=1, PAR_TYP=1, PRESCALE=32 -> bytes BB(p1), 18(p1); every bit held 32 cycles; total 768 cycles.
REQ-035 SHALL verify: ALU with operands, A=56, B=EC, FUN=10, PAR_EN=0, PRESCALE=4 -> CC, 56, EC, 10, no parity bits; total 176 cycles.
REQ-036 SHALL verify: PRESCALE=1, ALU without operands, FUN=AC, PAR_EN=0 -> clamped to P=4; DD, AC sent; total 88 cycles.
REQ-037 SHALL verify: CMD_VALID held high with fields changed mid-command -> changes ignored; second command's start bit begins the cycle after CMD_READY rises.
REQ-038 SHALL verify: RST pulsed during the DATA bits of byte 2 -> TX_OUT=1 and CMD_READY=1 asynchronously, no CMD_DONE; a new RF read afterwards completes correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Opcodes, command-type encodings and framer FSM states shared by the UART command transmitter.
package uart_cmd_pkg;

    localparam logic [7:0] RF_WR_CMD     = 8'hAA;
    localparam logic [7:0] RF_RD_CMD     = 8'hBB;
    localparam logic [7:0] ALU_W_OP_CMD  = 8'hCC;
    localparam logic [7:0] ALU_W_NOP_CMD = 8'hDD;

    typedef enum logic [1:0] {
        CMD_RF_WR      = 2'b00,
        CMD_RF_RD      = 2'b01,
        CMD_ALU_W_OP   = 2'b10,
        CMD_ALU_W_NOP  = 2'b11
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } tx_state_e;

    // Index of the final byte of each command's sequence (byte count minus one).
    function automatic logic [1:0] last_byte_idx(input cmd_type_e t);
        case (t)
            CMD_RF_WR:    last_byte_idx = 2'd2;
            CMD_RF_RD:    last_byte_idx = 2'd1;
            CMD_ALU_W_OP: last_byte_idx = 2'd3;
            default:      last_byte_idx = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..period-1 while running and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] period,
    output logic         bit_tick
);

    logic [W-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == period - W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || !run || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign bit_tick = run && !load && at_end;

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// Serialises register-file / ALU command byte sequences as UART frames on TX_OUT.
// state  | meaning
// IDLE   | ready for a command, line high
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | stop bit (1)
// GAP    | idle gap bit (1); next byte or done
module uart_cmd_frame_tx
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CMD_VALID,
    output logic                      CMD_READY,
    input  logic [1:0]                CMD_TYPE,
    input  logic [DATA_WIDTH-1:0]     CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]     CMD_DATA_A,
    input  logic [DATA_WIDTH-1:0]     CMD_DATA_B,
    input  logic [DATA_WIDTH-1:0]     CMD_FUN,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      BUSY,
    output logic                      CMD_DONE
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    tx_state_e                 state_q, state_n;
    logic [2:0]                bit_idx_q, bit_idx_n;
    logic [1:0]                byte_idx_q, byte_idx_n;
    logic                      tx_q, tx_n;

    cmd_type_e                 type_q;
    logic [DATA_WIDTH-1:0]     addr_q, a_q, b_q, fun_q;
    logic                      par_en_q, par_typ_q;
    logic [PRESCALE_WIDTH-1:0] period_q;

    logic                      accept;
    logic                      running;
    logic                      bit_tick;
    logic [1:0]                last_idx;
    logic [DATA_WIDTH-1:0]     frame_byte;

    assign accept   = CMD_VALID && (state_q == ST_IDLE);
    assign running  = (state_q != ST_IDLE);
    assign last_idx = last_byte_idx(type_q);

    // Everything the command needs is frozen at accept so the inputs are free afterwards.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            type_q    <= CMD_RF_WR;
            addr_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            fun_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            period_q  <= '0;
        end else if (accept) begin
            type_q    <= cmd_type_e'(CMD_TYPE);
            addr_q    <= CMD_ADDR;
            a_q       <= CMD_DATA_A;
            b_q       <= CMD_DATA_B;
            fun_q     <= CMD_FUN;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            period_q  <= (PRESCALE < PRESCALE_WIDTH'(4)) ? PRESCALE_WIDTH'(4) : PRESCALE;
        end
    end

    uart_baud_tick #(
        .W(PRESCALE_WIDTH)
    ) u_baud_tick (
        .clk      (CLK),
        .rst      (RST),
        .load     (accept),
        .run      (running),
        .period   (period_q),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_n;
            bit_idx_q  <= bit_idx_n;
            byte_idx_q <= byte_idx_n;
            tx_q       <= tx_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        bit_idx_n  = bit_idx_q;
        byte_idx_n = byte_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_n    = ST_START;
                    bit_idx_n  = '0;
                    byte_idx_n = '0;
                end
            end
            ST_START: begin
                if (bit_tick) state_n = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    bit_idx_n = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT) state_n = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_tick) state_n = ST_STOP;
            end
            ST_STOP: begin
                if (bit_tick) state_n = ST_GAP;
            end
            ST_GAP: begin
                if (bit_tick) begin
                    if (byte_idx_q == last_idx) begin
                        state_n    = ST_IDLE;
                        byte_idx_n = '0;
                    end else begin
                        state_n    = ST_START;
                        byte_idx_n = byte_idx_q + 2'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_byte = '0;
        case (type_q)
            CMD_RF_WR: begin
                case (byte_idx_n)
                    2'd0:    frame_byte = DATA_WIDTH'(RF_WR_CMD);
                    2'd1:    frame_byte = addr_q;
                    default: frame_byte = a_q;
                endcase
            end
            CMD_RF_RD: begin
                frame_byte = (byte_idx_n == 2'd0) ? DATA_WIDTH'(RF_RD_CMD) : addr_q;
            end
            CMD_ALU_W_OP: begin
                case (byte_idx_n)
                    2'd0:    frame_byte = DATA_WIDTH'(ALU_W_OP_CMD);
                    2'd1:    frame_byte = a_q;
                    2'd2:    frame_byte = b_q;
                    default: frame_byte = fun_q;
                endcase
            end
            default: begin
                frame_byte = (byte_idx_n == 2'd0) ? DATA_WIDTH'(ALU_W_NOP_CMD) : fun_q;
            end
        endcase
    end

    // The line level is computed for the upcoming state and registered, so TX_OUT is a flop.
    always_comb begin
        CMD_READY = (state_q == ST_IDLE);
        BUSY      = (state_q != ST_IDLE);
        CMD_DONE  = (state_q == ST_GAP) && bit_tick && (byte_idx_q == last_idx);
        case (state_n)
            ST_START:  tx_n = 1'b0;
            ST_DATA:   tx_n = frame_byte[bit_idx_n];
            ST_PARITY: tx_n = (^frame_byte) ^ par_typ_q;
            default:   tx_n = 1'b1;
        endcase
    end

    assign TX_OUT = tx_q;

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
// Scoreboard bench for uart_cmd_frame_tx: expected frames and durations are queued by the
// stimulus and consumed by independent line and completion monitors.
module tb_uart_cmd_frame_tx;

    logic       CLK;
    logic       RST;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_TYPE;
    logic [7:0] CMD_ADDR;
    logic [7:0] CMD_DATA_A;
    logic [7:0] CMD_DATA_B;
    logic [7:0] CMD_FUN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       BUSY;
    logic       CMD_DONE;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  b;
        logic [11:0] bits;
        int          nbits;
        int          p;
    } frame_t;

    frame_t exp_q[$];
    int     dur_q[$];

    uart_cmd_frame_tx dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_VALID  (CMD_VALID),
        .CMD_READY  (CMD_READY),
        .CMD_TYPE   (CMD_TYPE),
        .CMD_ADDR   (CMD_ADDR),
        .CMD_DATA_A (CMD_DATA_A),
        .CMD_DATA_B (CMD_DATA_B),
        .CMD_FUN    (CMD_FUN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .CMD_DONE   (CMD_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Queue one expected frame: start, data LSB first, optional parity, stop, gap.
    task automatic push_byte(input logic [7:0] b, input logic pe, input logic pbit, input int p);
        frame_t f;
        f.b    = b;
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = b[i];
        if (pe) begin
            f.bits[9] = pbit;
            f.nbits   = 12;
        end else begin
            f.nbits   = 11;
        end
        f.p = p;
        exp_q.push_back(f);
    endtask

    task automatic drive(input logic [1:0] t, input logic [7:0] ad, input logic [7:0] da,
                         input logic [7:0] db, input logic [7:0] fn, input logic pe,
                         input logic pt, input logic [5:0] ps);
        CMD_TYPE   = t;
        CMD_ADDR   = ad;
        CMD_DATA_A = da;
        CMD_DATA_B = db;
        CMD_FUN    = fn;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        PRESCALE   = ps;
        CMD_VALID  = 1'b1;
    endtask

    task automatic wait_accept(input bit hold);
        int n = 0;
        while (CMD_READY !== 1'b1 && n < 5000) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: CMD_READY still %b after %0d cycles, required 1", CMD_READY, n);
        end
        @(posedge CLK); #1;
        if (!hold) CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int  n = 0;
        bit  seen = 0;
        while (n < limit) begin
            @(negedge CLK);
            if (CMD_DONE === 1'b1) begin
                seen = 1;
                break;
            end
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_wait: no CMD_DONE within %0d cycles, required a pulse", limit);
        end
    endtask

    // Line monitor: every sample of every bit must match the queued frame.
    frame_t cur;
    bit     mon_active = 0;
    int     mon_bit;
    int     mon_cnt;
    bit     mon_bad;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                mon_active = 0;
            end else begin
                if (!mon_active && TX_OUT === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: TX_OUT went 0 with no frame queued");
                    end else begin
                        cur        = exp_q.pop_front();
                        mon_active = 1;
                        mon_bit    = 0;
                        mon_cnt    = 0;
                        mon_bad    = 0;
                    end
                end
                if (mon_active) begin
                    if (TX_OUT !== cur.bits[mon_bit]) mon_bad = 1;
                    mon_cnt++;
                    if (mon_cnt == cur.p) begin
                        checks++;
                        if (mon_bad) begin
                            errors++;
                            $display("FAIL tx_bit byte=%02h bit=%0d: line got other than required %b over its %0d cycles",
                                     cur.b, mon_bit, cur.bits[mon_bit], cur.p);
                        end
                        mon_bit++;
                        mon_cnt = 0;
                        mon_bad = 0;
                        if (mon_bit == cur.nbits) mon_active = 0;
                    end
                end
            end
        end
    end

    // Completion monitor: duration, first-cycle start bit, handshake after done.
    bit in_cmd    = 0;
    bit chk_ready = 0;
    int cyc;
    int exp_dur;

    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                in_cmd    = 0;
                chk_ready = 0;
            end else begin
                if (chk_ready) begin
                    check("ready_after_done", {BUSY, CMD_READY}, 2'b01);
                    chk_ready = 0;
                end
                if (in_cmd) begin
                    cyc++;
                    if (cyc == 1) check("start_in_cycle1", {TX_OUT, BUSY, CMD_READY}, 3'b010);
                    if (CMD_DONE === 1'b1) begin
                        check("done_cycle", cyc, exp_dur);
                        in_cmd    = 0;
                        chk_ready = 1;
                    end else if (cyc > exp_dur) begin
                        checks++;
                        errors++;
                        $display("FAIL done_late: no CMD_DONE by cycle %0d, required at %0d", cyc, exp_dur);
                        in_cmd = 0;
                    end
                end else if (CMD_DONE === 1'b1) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: CMD_DONE=1 with no command tracked, required 0");
                end
                if (CMD_VALID === 1'b1 && CMD_READY === 1'b1) begin
                    if (dur_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_accept: accept with no duration queued");
                    end else begin
                        exp_dur = dur_q.pop_front();
                        in_cmd  = 1;
                        cyc     = 0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        CMD_VALID = 1'b0;
        CMD_TYPE = 2'b00; CMD_ADDR = 8'h00; CMD_DATA_A = 8'h00; CMD_DATA_B = 8'h00;
        CMD_FUN = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = 6'd0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tx",    TX_OUT,    1);
        check("rst_ready", CMD_READY, 1);
        check("rst_busy",  BUSY,      0);
        check("rst_done",  CMD_DONE,  0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // RF write, even parity, P=8: 3 x 12 x 8
        push_byte(8'hAA, 1, 0, 8); push_byte(8'h14, 1, 0, 8); push_byte(8'h69, 1, 0, 8);
        dur_q.push_back(288);
        drive(2'b00, 8'h14, 8'h69, 8'h00, 8'h00, 1, 0, 6'd32 - 6'd24);
        wait_accept(0);
        wait_done(400);
        @(posedge CLK); #1;

        // RF read, odd parity, P=32: 2 x 12 x 32
        push_byte(8'hBB, 1, 1, 32); push_byte(8'h18, 1, 1, 32);
        dur_q.push_back(768);
        drive(2'b01, 8'h18, 8'h00, 8'h00, 8'h00, 1, 1, 6'd32);
        wait_accept(0);
        wait_done(1000);
        @(posedge CLK); #1;

        // ALU with operands, no parity, P=4: 4 x 11 x 4
        push_byte(8'hCC, 0, 0, 4); push_byte(8'h56, 0, 0, 4);
        push_byte(8'hEC, 0, 0, 4); push_byte(8'h10, 0, 0, 4);
        dur_q.push_back(176);
        drive(2'b10, 8'h00, 8'h56, 8'hEC, 8'h10, 0, 0, 6'd4);
        wait_accept(0);
        wait_done(300);
        @(posedge CLK); #1;

        // ALU without operands, PRESCALE=1 clamps to 4: 2 x 11 x 4
        push_byte(8'hDD, 0, 0, 4); push_byte(8'hAC, 0, 0, 4);
        dur_q.push_back(88);
        drive(2'b11, 8'h00, 8'h00, 8'h00, 8'hAC, 0, 0, 6'd1);
        wait_accept(0);
        wait_done(200);
        @(posedge CLK); #1;

        // Back-to-back with CMD_VALID held; fields change while the first is in flight
        push_byte(8'hBB, 0, 0, 4); push_byte(8'h5A, 0, 0, 4);
        dur_q.push_back(88);
        drive(2'b01, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 0, 6'd4);
        wait_accept(1);
        repeat (10) begin @(posedge CLK); #1; end
        push_byte(8'hAA, 1, 0, 5); push_byte(8'h3C, 1, 0, 5); push_byte(8'hC3, 1, 0, 5);
        dur_q.push_back(180);
        drive(2'b00, 8'h3C, 8'hC3, 8'h77, 8'h99, 1, 0, 6'd5);
        wait_done(200);
        @(negedge CLK);
        check("b2b_ready", CMD_READY, 1);
        @(negedge CLK);
        check("b2b_start_tx", TX_OUT, 0);
        check("b2b_start_busy", BUSY, 1);
        CMD_VALID = 1'b0;
        wait_done(300);
        @(posedge CLK); #1;

        // Reset during data bits of the second byte (0x11, bit1 low), then a fresh RF read
        push_byte(8'hAA, 0, 0, 4); push_byte(8'h11, 0, 0, 4); push_byte(8'h22, 0, 0, 4);
        dur_q.push_back(132);
        drive(2'b00, 8'h11, 8'h22, 8'h00, 8'h00, 0, 0, 6'd4);
        wait_accept(0);
        repeat (54) @(negedge CLK);
        check("pre_abort_tx", TX_OUT, 0);
        #2;
        RST = 1'b1;
        exp_q.delete();
        #1;
        check("abort_tx",    TX_OUT,    1);
        check("abort_ready", CMD_READY, 1);
        check("abort_busy",  BUSY,      0);
        check("abort_done",  CMD_DONE,  0);
        repeat (3) @(posedge CLK);
        #1;
        push_byte(8'hBB, 1, 0, 6); push_byte(8'h7E, 1, 0, 6);
        dur_q.push_back(144);
        drive(2'b01, 8'h7E, 8'h00, 8'h00, 8'h00, 1, 0, 6'd6);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("accept_after_rst", BUSY, 1);
        CMD_VALID = 1'b0;
        wait_done(300);

        repeat (5) @(posedge CLK);
        #1;
        check("frames_drained",    exp_q.size(), 0);
        check("durations_drained", dur_q.size(), 0);
        check("line_idle_end",     TX_OUT,       1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
